// File: rtl/data_type.sv
// Shared types and constants for the rx sample path.
package data_type;

    localparam int unsigned FFT_N = 256;  // FFT size / symbol body length
    localparam int unsigned CP_L  = 16;   // cyclic-prefix length
    localparam int unsigned CNT_W = 32;   // absolute sample counter width

    typedef logic signed [15:0]      in_r_t;
    typedef logic [8:0]              theta_t;
    typedef logic signed [15:0]      eps_t;
    typedef logic [$clog2(FFT_N)-1:0] sym_idx_t;
    typedef logic [CNT_W-1:0]        cnt_t;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_t;

endpackage

// File: rtl/ring_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module ring_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write on we; read data registered and held while re is low
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cp_strip_buffer.sv
// Ring-buffers the rx stream and replays the CP-free N-sample window of each estimator
// decision over a valid/ready port, tagged with symbol index and epsilon.
module cp_strip_buffer
    import data_type::*;
#(
    parameter int unsigned N     = FFT_N,
    parameter int unsigned L     = CP_L,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CW    = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  in_r_t                rx_re_in,
    input  in_r_t                rx_img_in,
    input  logic                 est_valid,
    input  theta_t               theta_in,
    input  eps_t                 eps_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output in_r_t                sym_re,
    output in_r_t                sym_im,
    output logic [$clog2(N)-1:0] sym_idx,
    output logic                 sym_last,
    output eps_t                 sym_eps,
    output logic                 ovf,
    output logic                 miss
);

    localparam int unsigned LogN = $clog2(N);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned DW   = 2 * $bits(in_r_t);
    localparam int unsigned IW   = LogN + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   wr_cnt_q, dec_cnt_q;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [IW-1:0]   iss_cnt_q, iss_cnt_d;  // reads issued for the active symbol
    eps_t            act_eps_q, act_eps_d;
    logic            pend_valid_q, pend_valid_d;
    logic [CW-1:0]   pend_start_q, pend_start_d;
    eps_t            pend_eps_q, pend_eps_d;
    logic            miss_q, miss_d;
    logic            ovf_q;

    // RAM output stage metadata and skid register
    logic            q_valid_q;
    logic [LogN-1:0] q_idx_q;
    eps_t            q_eps_q;
    logic            skid_valid_q;
    logic [DW-1:0]   skid_data_q;
    logic [LogN-1:0] skid_idx_q;
    eps_t            skid_eps_q;

    logic [DW-1:0]   ram_rdata;
    logic            ren, fire, last_fire, overrun;
    logic [CW-1:0]   start_w, protect, occupancy;

    ring_ram #(
        .DEPTH (DEPTH),
        .W     (DW)
    ) u_ring_ram (
        .clk   (clk),
        .we    (in_valid),
        .waddr (wr_cnt_q[AW-1:0]),
        .wdata ({rx_re_in, rx_img_in}),
        .re    (ren),
        .raddr (rd_cnt_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Window start, read issue and overflow detection
    always_comb begin
        start_w = (dec_cnt_q << LogN) + (CW'(theta_in) & CW'(N - 1)) + CW'(L);
        // Only issue when the skid is free, so at most two beats are ever in flight
        ren = (state_q == StActive) && (iss_cnt_q < IW'(N)) && (rd_cnt_q < wr_cnt_q) &&
              !skid_valid_q;
        if (state_q == StIdle) begin
            protect = wr_cnt_q;
        end else if (pend_valid_q && (pend_start_q < rd_cnt_q)) begin
            protect = pend_start_q;
        end else begin
            protect = rd_cnt_q;
        end
        // A future start makes the difference negative: nothing protected is at risk
        occupancy = wr_cnt_q - protect;
        overrun   = in_valid && !occupancy[CW-1] && (occupancy >= CW'(DEPTH));
    end

    // Output mux: the skid holds the older beat whenever it is occupied
    always_comb begin
        out_valid = skid_valid_q | q_valid_q;
        sym_re    = '0;
        sym_im    = '0;
        sym_idx   = '0;
        sym_eps   = '0;
        if (skid_valid_q) begin
            {sym_re, sym_im} = skid_data_q;
            sym_idx          = skid_idx_q;
            sym_eps          = skid_eps_q;
        end else if (q_valid_q) begin
            {sym_re, sym_im} = ram_rdata;
            sym_idx          = q_idx_q;
            sym_eps          = q_eps_q;
        end
        sym_last  = out_valid && (sym_idx == LogN'(N - 1));
        fire      = out_valid && out_ready;
        last_fire = fire && sym_last;
        ovf       = ovf_q;
        miss      = miss_q;
    end

    // Next-state: decision slots and window sequencing
    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        iss_cnt_d    = iss_cnt_q;
        act_eps_d    = act_eps_q;
        pend_valid_d = pend_valid_q;
        pend_start_d = pend_start_q;
        pend_eps_d   = pend_eps_q;
        miss_d       = miss_q;
        if (ren) begin
            rd_cnt_d  = rd_cnt_q + CW'(1);
            iss_cnt_d = iss_cnt_q + IW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (est_valid) begin
                    state_d   = StActive;
                    rd_cnt_d  = start_w;
                    iss_cnt_d = '0;
                    act_eps_d = eps_in;
                end
            end
            StActive: begin
                if (last_fire) begin
                    // A decision arriving now is ordered after the pending slot drains
                    if (pend_valid_q) begin
                        rd_cnt_d     = pend_start_q;
                        act_eps_d    = pend_eps_q;
                        iss_cnt_d    = '0;
                        pend_valid_d = est_valid;
                        if (est_valid) begin
                            pend_start_d = start_w;
                            pend_eps_d   = eps_in;
                        end
                    end else if (est_valid) begin
                        rd_cnt_d  = start_w;
                        act_eps_d = eps_in;
                        iss_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (est_valid) begin
                    if (!pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_start_d = start_w;
                        pend_eps_d   = eps_in;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters, FSM state, decision slots and sticky flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            wr_cnt_q     <= '0;
            dec_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            iss_cnt_q    <= '0;
            act_eps_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_start_q <= '0;
            pend_eps_q   <= '0;
            miss_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            iss_cnt_q    <= iss_cnt_d;
            act_eps_q    <= act_eps_d;
            pend_valid_q <= pend_valid_d;
            pend_start_q <= pend_start_d;
            pend_eps_q   <= pend_eps_d;
            miss_q       <= miss_d;
            if (in_valid) begin
                wr_cnt_q <= wr_cnt_q + CW'(1);
            end
            if (est_valid) begin
                dec_cnt_q <= dec_cnt_q + CW'(1);
            end
            if (overrun) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Read pipeline: RAM output stage plus skid for beats that were not accepted
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_valid_q    <= 1'b0;
            q_idx_q      <= '0;
            q_eps_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_idx_q   <= '0;
            skid_eps_q   <= '0;
        end else begin
            if (ren) begin
                q_valid_q <= 1'b1;
                q_idx_q   <= iss_cnt_q[LogN-1:0];
                q_eps_q   <= act_eps_q;
            end else if (fire && !skid_valid_q) begin
                q_valid_q <= 1'b0;
            end
            if (skid_valid_q) begin
                if (fire) begin
                    skid_valid_q <= 1'b0;
                end
            end else if (ren && q_valid_q && !fire) begin
                // RAM output is about to be overwritten by the new read
                skid_valid_q <= 1'b1;
                skid_data_q  <= ram_rdata;
                skid_idx_q   <= q_idx_q;
                skid_eps_q   <= q_eps_q;
            end
        end
    end

endmodule
